// File: rtl/bus68k_arbiter.sv
// Two-master, one-slave arbiter for a 68k-style bus. Grants last one transaction each.
// A watchdog forces an ack if the slave never answers.
module bus68k_arbiter #(
  parameter int ROUND_ROBIN = 1,
  parameter int TIMEOUT     = 255,
  parameter int TO_WIDTH    = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        m0_write_strobe,
  input  logic        m0_as,
  input  logic        m0_lds,
  input  logic        m0_uds,
  input  logic [22:0] m0_addr,
  input  logic [15:0] m0_data_out,
  output logic        m0_bus_ack,
  output logic [15:0] m0_data_in,
  input  logic        m1_write_strobe,
  input  logic        m1_as,
  input  logic        m1_lds,
  input  logic        m1_uds,
  input  logic [22:0] m1_addr,
  input  logic [15:0] m1_data_out,
  output logic        m1_bus_ack,
  output logic [15:0] m1_data_in,
  output logic        s_write_strobe,
  output logic        s_as,
  output logic        s_lds,
  output logic        s_uds,
  output logic [22:0] s_addr,
  output logic [15:0] s_data_out,
  input  logic        s_bus_ack,
  input  logic [15:0] s_data_in,
  output logic [1:0]  grant,
  output logic        timeout_pulse
);

  // IDLE: no owner | OWN0/OWN1: bus forwarded to owner | FORCED: watchdog ack held
  typedef enum logic [1:0] {IDLE, OWN0, OWN1, FORCED} state_t;

  localparam logic [TO_WIDTH-1:0] TO_LAST = TO_WIDTH'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  state_t              state_q, state_d;
  logic                last_q, last_d;
  logic                owner_q, owner_d;
  logic [TO_WIDTH-1:0] cnt_q, cnt_d;
  logic                pulse_q, pulse_d;
  logic                own_as;
  logic                pick;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      owner_q <= 1'b0;
      cnt_q   <= '0;
      pulse_q <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
      pulse_q <= pulse_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    last_d         = last_q;
    owner_d        = owner_q;
    cnt_d          = cnt_q;
    pick           = 1'b0;
    s_write_strobe = 1'b0;
    s_as           = 1'b0;
    s_lds          = 1'b0;
    s_uds          = 1'b0;
    s_addr         = '0;
    s_data_out     = '0;
    m0_bus_ack     = 1'b0;
    m0_data_in     = '0;
    m1_bus_ack     = 1'b0;
    m1_data_in     = '0;
    grant          = 2'b00;
    own_as         = owner_q ? m1_as : m0_as;

    unique case (state_q)
      IDLE: begin
        if (m0_as || m1_as) begin
          if (m0_as && m1_as) pick = (ROUND_ROBIN != 0) ? ~last_q : 1'b0;
          else                pick = m1_as;
          state_d = pick ? OWN1 : OWN0;
          owner_d = pick;
          last_d  = pick;
          cnt_d   = '0;
        end
      end
      OWN0, OWN1: begin
        grant = owner_q ? 2'b10 : 2'b01;
        if (owner_q) begin
          s_write_strobe = m1_write_strobe;
          s_as           = m1_as;
          s_lds          = m1_lds;
          s_uds          = m1_uds;
          s_addr         = m1_addr;
          s_data_out     = m1_data_out;
          m1_bus_ack     = s_bus_ack;
          m1_data_in     = s_data_in;
        end else begin
          s_write_strobe = m0_write_strobe;
          s_as           = m0_as;
          s_lds          = m0_lds;
          s_uds          = m0_uds;
          s_addr         = m0_addr;
          s_data_out     = m0_data_out;
          m0_bus_ack     = s_bus_ack;
          m0_data_in     = s_data_in;
        end
        // Owner release beats a real ack, which beats the watchdog.
        if (!own_as)                                 state_d = IDLE;
        else if (s_bus_ack)                          cnt_d   = '0;
        else if ((TIMEOUT > 0) && (cnt_q == TO_LAST)) state_d = FORCED;
        else                                         cnt_d   = cnt_q + TO_WIDTH'(1);
      end
      FORCED: begin
        grant = owner_q ? 2'b10 : 2'b01;
        if (owner_q) begin
          m1_bus_ack = 1'b1;
          m1_data_in = 16'hFFFF;
        end else begin
          m0_bus_ack = 1'b1;
          m0_data_in = 16'hFFFF;
        end
        if (!own_as) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    pulse_d = (state_d == FORCED) && (state_q != FORCED);
  end

  assign timeout_pulse = pulse_q;

endmodule

// File: tb/tb_bus68k_arbiter.sv
// Bench for bus68k_arbiter: a round-robin and a fixed-priority instance share stimulus
// and are compared every cycle against a transaction-level reference model.
module tb_bus68k_arbiter;

  localparam int TO = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n;
  logic [1:0]       m_ws, m_as, m_lds, m_uds;
  logic [1:0][22:0] m_addr;
  logic [1:0][15:0] m_dout;
  logic             s_ack;
  logic [15:0]      s_din;

  logic [1:0]       o_ws, o_as, o_lds, o_uds, o_ack0, o_ack1, o_pulse;
  logic [1:0][22:0] o_addr;
  logic [1:0][15:0] o_dout, o_din0, o_din1;
  logic [1:0][1:0]  o_grant;

  bus68k_arbiter #(.ROUND_ROBIN(1), .TIMEOUT(TO), .TO_WIDTH(8)) dut_rr (
    .clk(clk), .reset_n(reset_n),
    .m0_write_strobe(m_ws[0]), .m0_as(m_as[0]), .m0_lds(m_lds[0]), .m0_uds(m_uds[0]),
    .m0_addr(m_addr[0]), .m0_data_out(m_dout[0]), .m0_bus_ack(o_ack0[0]), .m0_data_in(o_din0[0]),
    .m1_write_strobe(m_ws[1]), .m1_as(m_as[1]), .m1_lds(m_lds[1]), .m1_uds(m_uds[1]),
    .m1_addr(m_addr[1]), .m1_data_out(m_dout[1]), .m1_bus_ack(o_ack1[0]), .m1_data_in(o_din1[0]),
    .s_write_strobe(o_ws[0]), .s_as(o_as[0]), .s_lds(o_lds[0]), .s_uds(o_uds[0]),
    .s_addr(o_addr[0]), .s_data_out(o_dout[0]), .s_bus_ack(s_ack), .s_data_in(s_din),
    .grant(o_grant[0]), .timeout_pulse(o_pulse[0])
  );

  bus68k_arbiter #(.ROUND_ROBIN(0), .TIMEOUT(TO), .TO_WIDTH(3)) dut_fp (
    .clk(clk), .reset_n(reset_n),
    .m0_write_strobe(m_ws[0]), .m0_as(m_as[0]), .m0_lds(m_lds[0]), .m0_uds(m_uds[0]),
    .m0_addr(m_addr[0]), .m0_data_out(m_dout[0]), .m0_bus_ack(o_ack0[1]), .m0_data_in(o_din0[1]),
    .m1_write_strobe(m_ws[1]), .m1_as(m_as[1]), .m1_lds(m_lds[1]), .m1_uds(m_uds[1]),
    .m1_addr(m_addr[1]), .m1_data_out(m_dout[1]), .m1_bus_ack(o_ack1[1]), .m1_data_in(o_din1[1]),
    .s_write_strobe(o_ws[1]), .s_as(o_as[1]), .s_lds(o_lds[1]), .s_uds(o_uds[1]),
    .s_addr(o_addr[1]), .s_data_out(o_dout[1]), .s_bus_ack(s_ack), .s_data_in(s_din),
    .grant(o_grant[1]), .timeout_pulse(o_pulse[1])
  );

  // Reference model: owner index (-1 = none), forced flag, unacked-cycle count, last winner.
  int md_own [2];
  bit md_frc [2];
  int md_cnt [2];
  int md_last[2];
  bit md_pulse[2];

  int    n_assert, n_fail;
  string tag;
  int    as_hi[2], pulse_cnt[2];
  logic [1:0] prev_g[2];
  logic [1:0] gq_rr[$], gq_fp[$];

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      md_own[k] = -1; md_frc[k] = 1'b0; md_cnt[k] = 0; md_last[k] = 1; md_pulse[k] = 1'b0;
    end
  endtask

  task automatic model_edge();
    int pick;
    for (int k = 0; k < 2; k++) begin
      md_pulse[k] = 1'b0;
      if (md_own[k] < 0) begin
        if (m_as[0] && m_as[1]) pick = (k == 0) ? 1 - md_last[k] : 0;
        else if (m_as[0])       pick = 0;
        else if (m_as[1])       pick = 1;
        else                    pick = -1;
        if (pick >= 0) begin
          md_own[k] = pick; md_last[k] = pick; md_cnt[k] = 0; md_frc[k] = 1'b0;
        end
      end else if (!m_as[md_own[k]]) begin
        md_own[k] = -1; md_frc[k] = 1'b0;
      end else if (!md_frc[k]) begin
        if (s_ack) md_cnt[k] = 0;
        else begin
          md_cnt[k]++;
          if (md_cnt[k] == TO) begin md_frc[k] = 1'b1; md_pulse[k] = 1'b1; end
        end
      end
    end
  endtask

  function automatic logic [79:0] exp_of(int k);
    logic [1:0]  g;
    logic        ws, as, lds, uds, a0, a1;
    logic [22:0] addr;
    logic [15:0] dout, d0, d1;
    int          o;
    g = 2'b00; ws = 0; as = 0; lds = 0; uds = 0; a0 = 0; a1 = 0;
    addr = '0; dout = '0; d0 = '0; d1 = '0;
    o = md_own[k];
    if (o >= 0) begin
      g = (o == 0) ? 2'b01 : 2'b10;
      if (md_frc[k]) begin
        if (o == 0) begin a0 = 1'b1; d0 = 16'hFFFF; end
        else        begin a1 = 1'b1; d1 = 16'hFFFF; end
      end else begin
        ws = m_ws[o]; as = m_as[o]; lds = m_lds[o]; uds = m_uds[o];
        addr = m_addr[o]; dout = m_dout[o];
        if (o == 0) begin a0 = s_ack; d0 = s_din; end
        else        begin a1 = s_ack; d1 = s_din; end
      end
    end
    return {g, ws, as, lds, uds, addr, dout, a0, d0, a1, d1, md_pulse[k]};
  endfunction

  function automatic logic [79:0] obs_of(int k);
    return {o_grant[k], o_ws[k], o_as[k], o_lds[k], o_uds[k], o_addr[k], o_dout[k],
            o_ack0[k], o_din0[k], o_ack1[k], o_din1[k], o_pulse[k]};
  endfunction

  task automatic check_all();
    for (int k = 0; k < 2; k++) begin
      n_assert++;
      assert (obs_of(k) === exp_of(k)) else begin
        n_fail++;
        $error("FAIL %s dut%0d observed=%h expected=%h", tag, k, obs_of(k), exp_of(k));
      end
    end
  endtask

  task automatic check(string name, logic [31:0] obs, logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s/%s observed=%h expected=%h", tag, name, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    check_all();
    for (int k = 0; k < 2; k++) begin
      as_hi[k]     += int'(o_as[k]);
      pulse_cnt[k] += int'(o_pulse[k]);
      if (prev_g[k] == 2'b00 && o_grant[k] != 2'b00) begin
        if (k == 0) gq_rr.push_back(o_grant[k]);
        else        gq_fp.push_back(o_grant[k]);
      end
      prev_g[k] = o_grant[k];
    end
    @(posedge clk);
    if (reset_n) model_edge();
    #1;
  endtask

  task automatic clear_counts();
    for (int k = 0; k < 2; k++) begin as_hi[k] = 0; pulse_cnt[k] = 0; end
  endtask

  task automatic pulse_reset();
    reset_n = 1'b0;
    model_reset();
    #1;
    check_all();
    reset_n = 1'b1;
  endtask

  logic [12:0] tas0 = 13'b0_0000_1101_1011;
  logic [12:0] tas1 = 13'b0_0110_1101_1111;
  logic [12:0] tack = 13'b0_0100_1001_0010;

  initial begin
    logic [7:0] v;
    n_assert = 0; n_fail = 0;
    m_ws = '0; m_as = '0; m_lds = '0; m_uds = '0; m_addr = '0; m_dout = '0;
    s_ack = 1'b0; s_din = '0;
    prev_g[0] = 2'b00; prev_g[1] = 2'b00;
    clear_counts();
    reset_n = 1'b0;
    model_reset();
    tag = "reset";
    #2 check_all();
    tick(); tick();
    reset_n = 1'b1;
    tick();

    tag = "single_read";
    m_as[0] = 1'b1; m_addr[0] = 23'h000100; m_lds[0] = 1'b1; m_uds[0] = 1'b1; m_ws[0] = 1'b0;
    m_dout[0] = 16'h5A5A;
    tick();
    #1;
    check("s_as_latency", 32'(o_as[0]), 32'h1);
    check("grant_own0", 32'(o_grant[0]), 32'h1);
    check("s_addr", 32'(o_addr[0]), 32'h000100);
    tick(); tick();
    s_ack = 1'b1; s_din = 16'hBEEF;
    #1;
    check("m0_data_in", 32'(o_din0[0]), 32'hBEEF);
    check("m0_ack", 32'(o_ack0[0]), 32'h1);
    check("m1_ack", 32'(o_ack1[0]), 32'h0);
    tick();
    m_as[0] = 1'b0; s_ack = 1'b0; s_din = 16'h0;
    tick();
    #1 check("grant_idle", 32'(o_grant[0]), 32'h0);
    tick();

    tag = "contention";
    pulse_reset();
    gq_rr.delete(); gq_fp.delete();
    for (int c = 0; c < 13; c++) begin
      m_as[0] = tas0[c]; m_as[1] = tas1[c]; s_ack = tack[c];
      s_din = 16'($urandom);
      m_addr[0] = 23'($urandom); m_addr[1] = 23'($urandom);
      m_dout[0] = 16'($urandom); m_dout[1] = 16'($urandom);
      m_ws = 2'($urandom); m_lds = 2'($urandom); m_uds = 2'($urandom);
      tick();
    end
    m_as = '0; s_ack = 1'b0;
    tick(); tick();
    v = '0;
    foreach (gq_rr[i]) if (i < 4) v[i*2 +: 2] = gq_rr[i];
    check("rr_order", {24'(gq_rr.size()), v}, {24'd4, 8'b10_01_10_01});
    v = '0;
    foreach (gq_fp[i]) if (i < 4) v[i*2 +: 2] = gq_fp[i];
    check("fp_order", {24'(gq_fp.size()), v}, {24'd4, 8'b10_01_01_01});

    tag = "timeout";
    clear_counts();
    m_as[0] = 1'b1; m_as[1] = 1'b0; s_ack = 1'b0;
    for (int c = 0; c < 10; c++) tick();
    #1;
    check("forced_ack", 32'(o_ack0[0]), 32'h1);
    check("forced_data", 32'(o_din0[0]), 32'hFFFF);
    check("forced_s_as", 32'(o_as[0]), 32'h0);
    check("forced_grant", 32'(o_grant[1]), 32'h1);
    m_as[0] = 1'b0;
    tick(); tick();
    check("s_as_cycles_rr", 32'(as_hi[0]), 32'd4);
    check("s_as_cycles_fp", 32'(as_hi[1]), 32'd4);
    check("pulse_cycles_rr", 32'(pulse_cnt[0]), 32'd1);
    check("pulse_cycles_fp", 32'(pulse_cnt[1]), 32'd1);

    tag = "ack_at_limit";
    clear_counts();
    m_as[0] = 1'b1;
    tick(); tick(); tick(); tick();
    s_ack = 1'b1; s_din = 16'h1234;
    #1 check("late_ack_data", 32'(o_din0[0]), 32'h1234);
    tick();
    m_as[0] = 1'b0; s_ack = 1'b0;
    tick(); tick();
    check("no_pulse_rr", 32'(pulse_cnt[0]), 32'd0);
    check("no_pulse_fp", 32'(pulse_cnt[1]), 32'd0);

    tag = "reset_mid";
    m_as[1] = 1'b1;
    tick(); tick();
    m_as[0] = 1'b1; s_ack = 1'b1;
    #1;
    check("pre_s_as", 32'(o_as[0]), 32'h1);
    check("pre_m1_ack", 32'(o_ack1[0]), 32'h1);
    reset_n = 1'b0;
    model_reset();
    #1;
    check("rst_s_as", 32'(o_as[0]), 32'h0);
    check("rst_grant", 32'(o_grant[0]), 32'h0);
    check("rst_m1_ack", 32'(o_ack1[0]), 32'h0);
    check_all();
    reset_n = 1'b1;
    s_ack = 1'b0;
    #1;
    tick();
    #1;
    check("post_rst_rr", 32'(o_grant[0]), 32'h1);
    check("post_rst_fp", 32'(o_grant[1]), 32'h1);
    m_as = '0;
    tick(); tick();

    tag = "random";
    pulse_reset();
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < 2; i++) if ($urandom_range(3) == 0) m_as[i] = ~m_as[i];
      m_addr[0] = 23'($urandom); m_addr[1] = 23'($urandom);
      m_dout[0] = 16'($urandom); m_dout[1] = 16'($urandom);
      m_ws = 2'($urandom); m_lds = 2'($urandom); m_uds = 2'($urandom);
      s_ack = ($urandom_range(2) == 0);
      s_din = 16'($urandom);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/bus68k_arbiter.md
Name: bus68k_arbiter

Overview:
- Two-master, one-slave arbiter for the 68k-style bus (write_strobe/as/lds/uds/addr/data_out from master, bus_ack/data_in from slave).
- Shares a single slave port (e.g. main RAM) between the CPU (m0) and a DMA/display fetcher (m1).
- Grants are per transaction. Arbitration is round-robin or fixed-priority.
- Includes a watchdog that terminates transactions the slave never acknowledges.

Parameters:
- ROUND_ROBIN, 1: 1 = alternate on contention; 0 = m0 always wins contention.
- TIMEOUT, 255: cycles without slave ack before a forced ack; 0 disables the watchdog.
- TO_WIDTH, 8: timeout counter width; must satisfy TIMEOUT < 2**TO_WIDTH.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- m0_write_strobe, m0_as, m0_lds, m0_uds  in  1 each  master 0 request strobes.
- m0_addr  in  23  master 0 word address [23:1].
- m0_data_out  in  16  master 0 write data.
- m0_bus_ack  out  1  ack to master 0.
- m0_data_in  out  16  read data to master 0.
- m1_*  (same set as m0)  master 1.
- s_write_strobe, s_as, s_lds, s_uds  out  1 each  forwarded strobes to slave.
- s_addr  out  23  forwarded address.
- s_data_out  out  16  forwarded write data.
- s_bus_ack  in  1  slave ack.
- s_data_in  in  16  slave read data.
- grant  out  2  one-hot current owner (bit0 = m0, bit1 = m1), 00 when idle.
- timeout_pulse  out  1  one-cycle pulse when the watchdog fires.

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE, grant=00, last=m1 (so m0 wins the first contention), timeout counter=0, timeout_pulse=0.
  - All s_* outputs 0. m*_bus_ack=0. m*_data_in=0000.
- States: IDLE, OWN0, OWN1, FORCED.
- IDLE:
  - Only m0_as=1 -> OWN0. Only m1_as=1 -> OWN1.
  - Both =1 with ROUND_ROBIN=1 -> grant the master not equal to `last`.
  - Both =1 with ROUND_ROBIN=0 -> OWN0.
  - Update `last` on every grant.
- OWNx:
  - s_* = mx_* combinationally. mx_bus_ack = s_bus_ack. Non-owner bus_ack=0.
  - mx_data_in = s_data_in. Non-owner data_in holds 0000.
  - Owner drops mx_as -> s_as drops in the same cycle; next edge -> IDLE.
  - This applies whether or not ack was seen; an abort before ack is legal and silent.
- Latency and spacing:
  - mx_as rising sampled at edge N -> s_as=1 during cycle N+1.
  - At least one IDLE cycle between back-to-back grants; s_as is low for at least 1 cycle between transactions.
- Non-owner requests:
  - Stay pending with no ack. Their inputs are ignored until granted.
  - The owner is never preempted; grant is held until the owner deasserts as.
- Watchdog (TIMEOUT>0):
  - Counter clears on entry to OWNx and whenever s_bus_ack=1.
  - Counter increments each OWNx cycle with s_as=1 and s_bus_ack=0.
  - When counter==TIMEOUT -> FORCED; timeout_pulse=1 for that transition cycle's following cycle only.
- FORCED:
  - All s_* outputs = 0.
  - Owner bus_ack=1 and owner data_in=FFFF, held until owner drops as.
  - Then -> IDLE. grant stays on the owner until then.
- Simultaneous events:
  - s_bus_ack=1 in the same cycle the counter would reach TIMEOUT -> real ack wins; no FORCED.
  - Owner drops as in the same cycle -> IDLE takes precedence over FORCED.
- Reset mid-transaction: outputs return to reset values immediately, asynchronously, including s_as=0.
- Width rules: addr/data pass unmodified; no byte swapping. lds/uds are forwarded exactly as driven.

Test Plan:
- Single m0 read, addr=0x000100; slave acks 2 cycles after s_as with data 0xBEEF -> s_as rises 1 cycle after m0_as, m0_data_in=BEEF, m0_bus_ack=1, m1_bus_ack=0, grant=01 then 00.
- Both masters assert as in the same cycle, three back-to-back rounds, ROUND_ROBIN=1 -> grant order m0, m1, m0; at least one s_as-low cycle between each.
- Same stimulus with ROUND_ROBIN=0 while m0 re-requests immediately -> m0 is granted every round; m1 is granted only when m0_as=0 in IDLE.
- Slave never acks, TIMEOUT=4 -> exactly 4 s_as-high cycles, then s_as=0, timeout_pulse single cycle, m0_bus_ack=1 with data FFFF until m0_as drops.
- Slave ack arrives on cycle TIMEOUT -> normal completion, timeout_pulse stays 0.
- reset_n pulsed low mid-transaction (OWN1, s_as=1) -> s_as, grant, m1_bus_ack go 0 asynchronously; after release, a pending m0 request is granted first.
